// File: rtl/elevator_pkg.sv
// Shared types and floor helpers for the elevator controller.
package elevator_pkg;

    localparam int STORY_W    = 3;
    localparam int NUM_FLOORS = 3;

    localparam logic [STORY_W-1:0] FLOOR_MIN = 3'd1;
    localparam logic [STORY_W-1:0] FLOOR_MAX = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
`ifdef ELEV_TIMEOUT_EN
        ,
        FAULT
`endif
    } state_t;

    function automatic logic story_valid(input logic [STORY_W-1:0] s);
        return (s >= FLOOR_MIN) && (s <= FLOOR_MAX);
    endfunction

    // One-hot request bit for the floor reported by the sensor; zero when unknown.
    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [STORY_W-1:0] s);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (s == STORY_W'(f)) m[f-1] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floors_above(input logic [STORY_W-1:0] s);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (story_valid(s) && (STORY_W'(f) > s)) m[f-1] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floors_below(input logic [STORY_W-1:0] s);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (story_valid(s) && (STORY_W'(f) < s)) m[f-1] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Saturating interval counter: load restarts the interval, expired marks its last cycle.
module elevator_timer #(
    parameter int CYCLES = 4,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/elevator_ctrl.sv
// Three-floor elevator controller with collective request latching.
// Define ELEV_TIMEOUT_EN to add the motion watchdog, the FAULT state and the fault port.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES  = 50_000_000,
    parameter int MOVE_TIMEOUT = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STORY_W-1:0]    story,
    input  logic [NUM_FLOORS-1:0] call_btn,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
`ifdef ELEV_TIMEOUT_EN
    ,
    output logic                  fault
`endif
);

    // Both timers share one counter width sized for the longer interval.
    localparam int TMR_MAX = (DOOR_CYCLES > MOVE_TIMEOUT) ? DOOR_CYCLES : MOVE_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t                state, state_d;
    logic                  dir_q, dir_d;
    logic [NUM_FLOORS-1:0] pend_d, req, cur, above, below;
    logic                  story_ok;
    logic                  door_restart, door_load, door_en, door_done;

    assign story_ok = story_valid(story);
    assign cur      = floor_bit(story);
    assign above    = floors_above(story);
    assign below    = floors_below(story);
    assign req      = pending | call_btn;

    assign door_restart = (state == DOOR_OPEN) && (|(call_btn & cur));
    assign door_load    = (state_d == DOOR_OPEN) && ((state != DOOR_OPEN) || door_restart);
    assign door_en      = (state == DOOR_OPEN);

    elevator_timer #(
        .CYCLES (DOOR_CYCLES),
        .CNT_W  (TMR_W)
    ) u_door_tmr (
        .clk     (clk),
        .rst     (rst),
        .load    (door_load),
        .enable  (door_en),
        .expired (door_done)
    );

`ifdef ELEV_TIMEOUT_EN
    logic [STORY_W-1:0] story_q;
    logic               moving, wd_load, wd_expired, wd_trip;

    assign moving  = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign wd_load = !moving || (story != story_q);
    assign wd_trip = moving && !wd_load && wd_expired;

    // The cycle that observes a new story is spent reloading, hence one less.
    elevator_timer #(
        .CYCLES (MOVE_TIMEOUT - 1),
        .CNT_W  (TMR_W)
    ) u_wd_tmr (
        .clk     (clk),
        .rst     (rst),
        .load    (wd_load),
        .enable  (moving),
        .expired (wd_expired)
    );
`endif

    always_comb begin
        state_d = state;
        pend_d  = pending;
        dir_d   = dir_q;
        case (state)
            IDLE: begin
                pend_d = req;
                if (story_ok) begin
                    if (|(req & cur)) begin
                        state_d = DOOR_OPEN;
                    end else if (|(req & (dir_q ? above : below))) begin
                        state_d = dir_q ? MOVE_UP : MOVE_DOWN;
                    end else if (|(req & (dir_q ? below : above))) begin
                        state_d = dir_q ? MOVE_DOWN : MOVE_UP;
                        dir_d   = ~dir_q;
                    end
                end
            end
            MOVE_UP: begin
                pend_d = req;
                if (|(req & cur)) begin
                    state_d = DOOR_OPEN;
                end else if (story == FLOOR_MAX) begin
                    state_d = IDLE;
`ifdef ELEV_TIMEOUT_EN
                end else if (wd_trip) begin
                    state_d = FAULT;
`endif
                end
            end
            MOVE_DOWN: begin
                pend_d = req;
                if (|(req & cur)) begin
                    state_d = DOOR_OPEN;
                end else if (story == FLOOR_MIN) begin
                    state_d = IDLE;
`ifdef ELEV_TIMEOUT_EN
                end else if (wd_trip) begin
                    state_d = FAULT;
`endif
                end
            end
            DOOR_OPEN: begin
                // A press for the open floor only extends the door, it never latches.
                pend_d = pending | (call_btn & ~cur);
                if (!door_restart && door_done) state_d = IDLE;
            end
`ifdef ELEV_TIMEOUT_EN
            FAULT: begin
                state_d = FAULT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        if ((state_d == DOOR_OPEN) && (state != DOOR_OPEN)) pend_d = pend_d & ~cur;
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            dir_q      <= 1'b1;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            door_open  <= 1'b0;
`ifdef ELEV_TIMEOUT_EN
            fault      <= 1'b0;
            story_q    <= '0;
`endif
        end else begin
            state      <= state_d;
            pending    <= pend_d;
            dir_q      <= dir_d;
            motor_up   <= (state_d == MOVE_UP);
            motor_down <= (state_d == MOVE_DOWN);
            door_open  <= (state_d == DOOR_OPEN);
`ifdef ELEV_TIMEOUT_EN
            fault      <= (state_d == FAULT);
            story_q    <= story;
`endif
        end
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboarded bench for elevator_ctrl driving a simple car plant model.
module tb_elevator_ctrl;

    localparam int DOOR = 4;
    localparam int TMO  = 20;
    localparam int P    = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] story;
    logic [2:0] call_btn;
    logic       motor_up, motor_down, door_open;
    logic [2:0] pending;
`ifdef ELEV_TIMEOUT_EN
    logic       fault;
`endif

    elevator_ctrl #(
        .DOOR_CYCLES  (DOOR),
        .MOVE_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .story      (story),
        .call_btn   (call_btn),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .pending    (pending)
`ifdef ELEV_TIMEOUT_EN
        ,
        .fault      (fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int floor;
        int len;
    } stop_t;

    stop_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    pos      = 0;
    bit    hold     = 1'b0;
    bit    motor_seen = 1'b0;
    int    model_floor;
    bit    model_dir;

    function automatic logic [2:0] story_of(input int p);
        if (p % P == 0) return 3'(p / P + 1);
        return 3'd0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Car plant: one position unit per cycle of motor drive, P units per floor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold) begin
                story = 3'd0;
            end else begin
                if (motor_up && pos < 2 * P) pos++;
                else if (motor_down && pos > 0) pos--;
                story = story_of(pos);
            end
            if (motor_up || motor_down) motor_seen = 1'b1;
        end
    end

    // Monitor: interlock every cycle, and one scoreboard entry per door opening.
    initial begin
        bit    prev_door = 1'b0;
        int    len = 0;
        int    fl  = 0;
        stop_t e;
        forever begin
            @(negedge clk);
            checks++;
            if ((motor_up && motor_down) || (door_open && (motor_up || motor_down))) begin
                failures++;
                $display("FAIL interlock: up=%0b down=%0b door=%0b", motor_up, motor_down, door_open);
            end
            if (door_open && !prev_door) begin
                fl  = int'(story);
                len = 1;
            end else if (door_open) begin
                len++;
            end
            if (!door_open && prev_door) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_stop: floor %0d, none expected", fl);
                end else begin
                    e = exp_q.pop_front();
                    chk("stop_floor", fl, e.floor);
                    chk("door_len", len, e.len);
                end
            end
            prev_door = door_open;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic press(input logic [2:0] b);
        call_btn = b;
        @(negedge clk);
        call_btn = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic home(input int floor);
        hold  = 1'b0;
        pos   = (floor - 1) * P;
        story = story_of(pos);
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        for (int i = 0; i < 600 && quiet < 3; i++) begin
            @(negedge clk);
            if (!motor_up && !motor_down && !door_open && pending == 3'b000) quiet++;
            else quiet = 0;
        end
        chk({name, "_idle"}, int'(quiet >= 3), 1);
    endtask

    task automatic push_stop(input int floor, input int len);
        stop_t s;
        s.floor = floor;
        s.len   = len;
        exp_q.push_back(s);
    endtask

    // Reference: serve the current floor, then nearest requests in travel direction, reversing when none remain.
    task automatic model_batch(input logic [2:0] bits);
        bit [3:0] r;
        int       nxt;
        r = {bits, 1'b0};
        if (r[model_floor]) begin
            push_stop(model_floor, DOOR);
            r[model_floor] = 1'b0;
        end
        while (r != 4'b0000) begin
            nxt = 0;
            if (model_dir) begin
                for (int k = model_floor + 1; k <= 3; k++) if (r[k] && nxt == 0) nxt = k;
            end else begin
                for (int k = model_floor - 1; k >= 1; k--) if (r[k] && nxt == 0) nxt = k;
            end
            if (nxt == 0) begin
                model_dir = ~model_dir;
            end else begin
                push_stop(nxt, DOOR);
                r[nxt]      = 1'b0;
                model_floor = nxt;
            end
        end
    endtask

    initial begin
        int         n;
        logic [2:0] bits;
        call_btn = 3'b000;
        story    = 3'd1;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_motor_up", int'(motor_up), 0);
        chk("rst_motor_down", int'(motor_down), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_pending", int'(pending), 0);
`ifdef ELEV_TIMEOUT_EN
        chk("rst_fault", int'(fault), 0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single call from floor 1 to floor 3
        push_stop(3, DOOR);
        press(3'b100);
        chk("up_pending", int'(pending), 4);
        chk("up_motor", int'(motor_up), 1);
        n = 0;
        while (!door_open && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("up_door_reached", int'(door_open), 1);
        chk("up_door_story", int'(story), 3);
        chk("up_door_motor", int'(motor_up), 0);
        chk("up_door_pending", int'(pending), 0);
        wait_idle("up");

        // Call for floor 2 arriving while travelling up between floors
        do_reset();
        home(1);
        repeat (2) @(negedge clk);
        push_stop(2, DOOR);
        push_stop(3, DOOR);
        press(3'b100);
        chk("onfly_between", int'(story), 0);
        press(3'b010);
        wait_idle("onfly");
        chk("onfly_final", int'(story), 3);

        // Current-floor call and door extension
        motor_seen = 1'b0;
        push_stop(3, DOOR);
        press(3'b100);
        wait_idle("here");
        push_stop(3, 3 + DOOR);
        press(3'b100);
        chk("ext_door_open", int'(door_open), 1);
        repeat (2) @(negedge clk);
        press(3'b100);
        chk("ext_no_pending", int'(pending), 0);
        wait_idle("ext");
        chk("here_no_motor", int'(motor_seen), 0);

        // Car stuck between floors while moving down
        call_btn = 3'b001;
        hold     = 1'b1;
        @(negedge clk);
        call_btn = 3'b000;
        chk("stuck_motor_down", int'(motor_down), 1);
`ifdef ELEV_TIMEOUT_EN
        n = 1;
        while (!fault && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("fault_raised", int'(fault), 1);
        chk("fault_delay", int'((n - 1) >= 19 && (n - 1) <= 21), 1);
        chk("fault_motor_up", int'(motor_up), 0);
        chk("fault_motor_down", int'(motor_down), 0);
        chk("fault_door", int'(door_open), 0);
        press(3'b010);
        chk("fault_ignores_calls", int'(pending), 0);
`else
        repeat (30) @(negedge clk);
        chk("stuck_keeps_down", int'(motor_down), 1);
        chk("stuck_door", int'(door_open), 0);
`endif
        do_reset();
        home(1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a move
        press(3'b110);
        chk("mid_pending", int'(pending), 6);
        chk("mid_moving", int'(motor_up), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_up", int'(motor_up), 0);
        chk("mid_rst_down", int'(motor_down), 0);
        chk("mid_rst_door", int'(door_open), 0);
        chk("mid_rst_pending", int'(pending), 0);
`ifdef ELEV_TIMEOUT_EN
        chk("mid_rst_fault", int'(fault), 0);
`endif
        rst = 1'b0;
        home(1);
        repeat (3) @(negedge clk);

        // Randomized call batches issued to an idle car
        model_floor = 1;
        model_dir   = 1'b1;
        for (int b = 0; b < 12; b++) begin
            bits = 3'($urandom_range(7, 1));
            model_batch(bits);
            press(bits);
            wait_idle("batch");
            chk("batch_floor", int'(story), model_floor);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter DOOR_CYCLES, default 50_000_000: number of clk cycles the door stays open per stop.
REQ-002 Parameter MOVE_TIMEOUT, default 500_000_000: maximum number of clk cycles in a move state without a change in story.
REQ-003 Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- story  input  3  current floor code from the sensor decode stage; 1..3 are valid, all other values mean unknown.
- call_btn  input  3  floor request levels; bit0 is floor 1 and bit2 is floor 3.
- motor_up  output  1  drive car upward.
- motor_down  output  1  drive car downward.
- door_open  output  1  door open command.
- pending  output  3  latched outstanding requests.
- fault  output  1  motion watchdog tripped; only present with ELEV_TIMEOUT_EN.

Function
REQ-004 All outputs shall be registered and shall change only on the rising edge of clk.
REQ-005 Request latch: a set call_btn bit shall set the matching pending bit on the next edge. A pending bit shall clear on entry to DOOR_OPEN at that floor.
REQ-006 The FSM states shall be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN and FAULT. FAULT exists only with ELEV_TIMEOUT_EN.
REQ-007 A 1-bit direction register dir_q shall record the last travel direction (1 = up). Its reset value is 1.
REQ-008 IDLE transitions, evaluated in this priority order:
- story unknown: stay in IDLE.
- pending at the current floor: go to DOOR_OPEN.
- a request exists in direction dir_q: move in that direction.
- a request exists in the opposite direction: move that way and flip dir_q.
- otherwise stay in IDLE.
REQ-009 MOVE_UP shall assert motor_up. When story equals a floor whose pending bit is set, it shall go to DOOR_OPEN with the motor deasserted on that same edge. When story=3 and no request is pending, it shall go to IDLE.
REQ-010 MOVE_DOWN shall mirror MOVE_UP, using floor 1 as the end limit.
REQ-011 An unknown story during a move state shall keep the current motor output; it is a between-floors condition, not an error.
REQ-012 DOOR_OPEN shall assert door_open for exactly DOOR_CYCLES cycles and then go to IDLE. Both motor outputs shall be 0 throughout.
REQ-013 A call_btn press for the current floor during DOOR_OPEN shall restart the door counter and shall not set pending.
REQ-014 Requests arriving during a move are served in travel order on the fly. A floor that is already passed is served after the direction reverses.
REQ-015 motor_up and motor_down shall never be 1 in the same cycle, and door_open shall never be 1 while either motor output is 1.
REQ-016 The door counter and watchdog counter shall saturate and shall never wrap.

Reset
REQ-017 When rst=1 on a clock edge, the block shall enter IDLE with the following register values: pending=0, dir_q=1, all counters=0, motor_up=0, motor_down=0, door_open=0, fault=0.
REQ-018 Reset asserted mid-move or mid-door shall take effect on the next edge and discard pending requests.

Configuration
REQ-019 Macro ELEV_TIMEOUT_EN shall control the motion watchdog.
- Defined: if a move state lasts MOVE_TIMEOUT cycles without story changing, the block enters FAULT. FAULT drives both motors off, door_open=0 and fault=1, and holds until rst. Requests are ignored in FAULT.
- Undefined: no watchdog, no FAULT state, fault port absent, and MOVE_TIMEOUT is unused.

Structure
REQ-020 Package elevator_pkg shall hold:
- the FSM state enum;
- floor constants FLOOR_MIN=1 and FLOOR_MAX=3;
- the story width (3).
REQ-021 The door and watchdog counting shall be a single reusable sub-module elevator_timer. Its ports are load, enable and expired, and it is instantiated twice.

Verification
REQ-022 Apply DOOR_CYCLES=4 and MOVE_TIMEOUT=20 to every scenario below.
REQ-023 Idle car at story=1, pulse call_btn=3'b100 -> pending=100 next cycle and motor_up=1. When story is set to 3: motor_up=0, door_open=1 for 4 cycles, pending=000, then IDLE.
REQ-024 Car moving up from floor 1 with pending=100, press floor 2 while story=0 -> the car stops at story=2 first, then continues up to 3.
REQ-025 Call at the current floor while idle -> door_open=1 with no motor pulse. A re-press during the open window extends door_open to 4 cycles after the re-press.
REQ-026 Moving down with story held at 0 for 20 cycles -> fault=1 and motors off (with ELEV_TIMEOUT_EN). Without the macro, motor_down stays 1.
REQ-027 Assert rst mid-move with pending=110 -> next cycle all outputs are 0 and pending=000. A checker shall assert REQ-015 in every cycle.
